// File: rtl/ram_rw_chk.sv
// ram_rw_chk: single-port RAM exerciser and checker.
// Each pass writes a pattern to addresses 0..DEPTH-1, reads them back, and
// compares every word against the regenerated pattern. The optional
// saturating mismatch counter (err_cnt) is built when RAM_RW_ERR_CNT_EN
// is defined.
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | one write per cycle, addresses ascending
// READ    | one read per cycle, addresses ascending
// DRAIN   | RD_LAT cycles for the last read data to return
// DONE    | one-cycle done pulse, pass updated, optionally loop
module ram_rw_chk #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_en,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr
`ifdef RAM_RW_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [1:0]          drain_q, drain_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   exp_q [RD_LAT];
  logic [DATA_W-1:0]   exp_d [RD_LAT];
  logic [ADDR_W-1:0]   cadr_q [RD_LAT];
  logic [ADDR_W-1:0]   cadr_d [RD_LAT];
  logic                write_entry;
  logic                mismatch;
`ifdef RAM_RW_ERR_CNT_EN
  logic [15:0]         err_cnt_q, err_cnt_d;
`endif

  // Pattern word for one address; a is the address resized to DATA_W.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] seed,
                                                input logic [1:0]        pmode);
    logic [DATA_W-1:0] a, sum, chk;
    logic              odd_phase;
    int unsigned       idx;
    a         = DATA_W'(addr);
    sum       = a + seed;
    odd_phase = a[0] ^ seed[0];
    for (int i = 0; i < DATA_W; i++) chk[i] = ~(odd_phase ^ 1'(i % 2));
    idx = 32'(sum) % DATA_W;
    case (pmode)
      2'b00:   return sum;
      2'b01:   return ~sum;
      2'b10:   return chk;
      default: return {{(DATA_W-1){1'b0}}, 1'b1} << idx;
    endcase
  endfunction

  assign write_entry = ((state_q == S_IDLE) && start) || ((state_q == S_DONE) && loop);
  assign mismatch    = vld_q[RD_LAT-1] && (ram_rd_data != exp_q[RD_LAT-1]);

  // Sequencer: next state and next registered RAM/status outputs.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    seed_d        = seed_q;
    ram_en_d      = 1'b0;
    ram_wea_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    drain_d       = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_WRITE;
          mode_d        = mode;
          seed_d        = '0;
          ram_en_d      = 1'b1;
          ram_wea_d     = 1'b1;
          ram_addr_d    = '0;
          ram_wr_data_d = pattern('0, '0, mode);
          busy_d        = 1'b1;
        end
      end
      S_WRITE: begin
        ram_en_d = 1'b1;
        if (ram_addr_q == LAST_ADDR) begin
          state_d    = S_READ;
          ram_addr_d = '0;
        end else begin
          ram_wea_d     = 1'b1;
          ram_addr_d    = ram_addr_q + ADDR_W'(1);
          ram_wr_data_d = pattern(ram_addr_q + ADDR_W'(1), seed_q, mode_q);
        end
      end
      S_READ: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 2'(RD_LAT - 1);
        end else begin
          ram_en_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // The final compare lands in this cycle, so fold it in directly.
          pass_d  = ~(fail_q | mismatch);
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      S_DONE: begin
        if (loop) begin
          state_d       = S_WRITE;
          seed_d        = seed_q + DATA_W'(1);
          ram_en_d      = 1'b1;
          ram_wea_d     = 1'b1;
          ram_addr_d    = '0;
          ram_wr_data_d = pattern('0, seed_q + DATA_W'(1), mode_q);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Checker: expected-word pipeline aligned with read data, fail tracking.
  always_comb begin
    vld_d[0]  = ram_en_q & ~ram_wea_q;
    exp_d[0]  = pattern(ram_addr_q, seed_q, mode_q);
    cadr_d[0] = ram_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      exp_d[i]  = exp_q[i-1];
      cadr_d[i] = cadr_q[i-1];
    end
    fail_d     = fail_q;
    err_addr_d = err_addr_q;
    if (write_entry) begin
      fail_d = 1'b0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) err_addr_d = cadr_q[RD_LAT-1];
    end
`ifdef RAM_RW_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (write_entry)                          err_cnt_d = '0;
    else if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= '0;
      seed_q        <= '0;
      ram_en_q      <= 1'b0;
      ram_wea_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_addr_q    <= '0;
      drain_q       <= '0;
      vld_q         <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= '0;
        cadr_q[i] <= '0;
      end
`ifdef RAM_RW_ERR_CNT_EN
      err_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      seed_q        <= seed_d;
      ram_en_q      <= ram_en_d;
      ram_wea_q     <= ram_wea_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      err_addr_q    <= err_addr_d;
      drain_q       <= drain_d;
      vld_q         <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= exp_d[i];
        cadr_q[i] <= cadr_d[i];
      end
`ifdef RAM_RW_ERR_CNT_EN
      err_cnt_q     <= err_cnt_d;
`endif
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_wea     = ram_wea_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_addr    = err_addr_q;
`ifdef RAM_RW_ERR_CNT_EN
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_ram_rw_chk.sv
// Testbench for ram_rw_chk: a default instance (8x32, RD_LAT=1) and a wide
// instance (16-bit, DEPTH=40, RD_LAT=2), each with a behavioural RAM.
// err_cnt is checked when RAM_RW_ERR_CNT_EN is defined.
module tb_ram_rw_chk;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         sel;
  logic       cur_start;
  logic [1:0] cur_mode;
  logic       cur_loop;
  logic       fault_en;

  // default instance
  logic        start0, loop0, en0, wea0, busy0, done0, pass0;
  logic [7:0]  rd0, wd0;
  logic [4:0]  addr0, ea0;
  // wide instance
  logic        start1, loop1, en1, wea1, busy1, done1, pass1;
  logic [15:0] rd1, rd1a, wd1;
  logic [5:0]  addr1, ea1;
`ifdef RAM_RW_ERR_CNT_EN
  logic [15:0] ec0, ec1;
`endif

  assign start0 = cur_start & (sel == 0);
  assign loop0  = cur_loop  & (sel == 0);
  assign start1 = cur_start & (sel == 1);
  assign loop1  = cur_loop  & (sel == 1);

  ram_rw_chk u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(cur_mode), .loop(loop0),
    .ram_rd_data(rd0), .ram_en(en0), .ram_wea(wea0), .ram_addr(addr0),
    .ram_wr_data(wd0), .busy(busy0), .done(done0), .pass(pass0), .err_addr(ea0)
`ifdef RAM_RW_ERR_CNT_EN
    , .err_cnt(ec0)
`endif
  );

  ram_rw_chk #(.DATA_W(16), .ADDR_W(6), .DEPTH(40), .RD_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(cur_mode), .loop(loop1),
    .ram_rd_data(rd1), .ram_en(en1), .ram_wea(wea1), .ram_addr(addr1),
    .ram_wr_data(wd1), .busy(busy1), .done(done1), .pass(pass1), .err_addr(ea1)
`ifdef RAM_RW_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );

  // RAM models: one-cycle read (optional bit-3 fault on addr 5/9), two-cycle read.
  logic [7:0]  mem0 [32];
  logic [15:0] mem1 [64];
  always @(posedge clk) begin
    if (en0) begin
      if (wea0) mem0[addr0] <= wd0;
      else rd0 <= mem0[addr0] ^ ((fault_en && (addr0 == 5'd5 || addr0 == 5'd9)) ? 8'h08 : 8'h00);
    end
    if (en1) begin
      if (wea1) mem1[addr1] <= wd1;
      else rd1a <= mem1[addr1];
    end
    rd1 <= rd1a;
  end

  logic        m_en, m_wea, m_busy, m_done, m_pass;
  logic [31:0] m_addr, m_wd;
  assign m_en   = (sel == 0) ? en0   : en1;
  assign m_wea  = (sel == 0) ? wea0  : wea1;
  assign m_busy = (sel == 0) ? busy0 : busy1;
  assign m_done = (sel == 0) ? done0 : done1;
  assign m_pass = (sel == 0) ? pass0 : pass1;
  assign m_addr = (sel == 0) ? 32'(addr0) : 32'(addr1);
  assign m_wd   = (sel == 0) ? 32'(wd0)   : 32'(wd1);

  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} acc_t;
  acc_t        wq[$];
  acc_t        rq[$];
  logic [31:0] exp_q[$];
  int          done_cyc[$];
  logic        pass_at_done[$];
  int          busy_low;
  logic        busy_at1;
  logic        timeout;

  function automatic logic [31:0] exp_pat(int dw, int a, int s, int m);
    logic [31:0] mask, sum, aa;
    mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    sum  = (32'(a) + 32'(s)) & mask;
    aa   = 32'hAAAA_AAAA;
    case (m)
      0:       return sum;
      1:       return ~sum & mask;
      2:       return (((a ^ s) & 1) != 0) ? (aa & mask) : (~aa & mask);
      default: return 32'd1 << (sum % 32'(dw));
    endcase
  endfunction

  // Starts a run on instance s and records writes, reads, done pulses and busy.
  // Cycle 0 is the cycle in which start is sampled.
  task automatic run(input int s, input logic [1:0] m, input logic lp,
                     input int npass, input int max_cyc, input int poke_cyc);
    int cyc;
    wq.delete(); rq.delete(); done_cyc.delete(); pass_at_done.delete();
    busy_low = -1; timeout = 1'b0; busy_at1 = 1'b0;
    @(negedge clk);
    sel = s; cur_mode = m; cur_loop = lp; cur_start = 1'b1;
    @(negedge clk);
    cur_start = 1'b0;
    cyc = 1;
    while (1) begin
      if (cyc == 1) busy_at1 = m_busy;
      if (m_en && m_wea)  wq.push_back('{cyc, m_addr, m_wd});
      if (m_en && !m_wea) rq.push_back('{cyc, m_addr, 32'd0});
      if (m_done) begin
        done_cyc.push_back(cyc);
        pass_at_done.push_back(m_pass);
      end
      if (!m_busy && busy_low < 0) busy_low = cyc;
      if (done_cyc.size() == npass && !m_busy) break;
      if (done_cyc.size() > 0 && done_cyc.size() == npass - 1 && cyc == done_cyc[$] + 1)
        cur_loop = 1'b0;
      if (cyc == poke_cyc) begin cur_start = 1'b1; cur_mode = ~m; end
      if (cyc == poke_cyc + 3) cur_start = 1'b0;
      if (cyc >= max_cyc) begin timeout = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en0, wea0, addr0, wd0, busy0, done0, pass0, ea0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got %h, expected 0", {en0, wea0, addr0, wd0, busy0, done0, pass0, ea0});
    end
    checks++;
    if ({en1, wea1, addr1, wd1, busy1, done1, pass1, ea1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got %h, expected 0", {en1, wea1, addr1, wd1, busy1, done1, pass1, ea1});
    end
`ifdef RAM_RW_ERR_CNT_EN
    checks++;
    if (ec0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_errcnt: got %h, expected 0", ec0);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({en0, busy0, done0, pass0} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, expected 0000", {en0, busy0, done0, pass0});
    end
  endtask

  task automatic test_mode0;
    logic [31:0] e;
    exp_q.delete();
    for (int a = 0; a < 32; a++) exp_q.push_back(exp_pat(8, a, 0, 0));
    run(0, 2'b00, 1'b0, 1, 200, -10);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL mode0_timeout: got timeout, expected done");
    end
    checks++;
    if (wq.size() != 32) begin
      errors++;
      $display("FAIL mode0_nwrites: got %0d, expected 32", wq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (wq[i].data !== e || wq[i].addr !== 32'(i) || wq[i].cyc != i + 1) begin
        errors++;
        $display("FAIL mode0_write[%0d]: got a=%0d d=%h c=%0d, expected a=%0d d=%h c=%0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, i, e, i + 1);
      end
    end
    checks++;
    if (rq.size() != 32) begin
      errors++;
      $display("FAIL mode0_nreads: got %0d, expected 32", rq.size());
    end
    for (int i = 0; i < rq.size(); i++) begin
      checks++;
      if (rq[i].addr !== 32'(i) || rq[i].cyc != 33 + i) begin
        errors++;
        $display("FAIL mode0_read[%0d]: got a=%0d c=%0d, expected a=%0d c=%0d",
                 i, rq[i].addr, rq[i].cyc, i, 33 + i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 66) begin
      errors++;
      $display("FAIL mode0_done: got n=%0d cyc=%0d, expected n=1 cyc=66", done_cyc.size(), done_cyc[0]);
    end
    checks++;
    if (pass_at_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode0_pass: got %b, expected 1", pass_at_done[0]);
    end
    checks++;
    if (busy_at1 !== 1'b1 || busy_low != 67) begin
      errors++;
      $display("FAIL mode0_busy: got busy@1=%b low@%0d, expected 1 and 67", busy_at1, busy_low);
    end
`ifdef RAM_RW_ERR_CNT_EN
    checks++;
    if (ec0 !== 16'd0) begin
      errors++;
      $display("FAIL mode0_errcnt: got %0d, expected 0", ec0);
    end
`endif
  endtask

  task automatic test_loop;
    logic [31:0] e;
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 32; a++) exp_q.push_back(exp_pat(8, a, p, 0));
    run(0, 2'b00, 1'b1, 2, 300, -10);
    checks++;
    if (timeout !== 1'b0 || wq.size() != 64) begin
      errors++;
      $display("FAIL loop_nwrites: got %0d timeout=%b, expected 64 timeout=0", wq.size(), timeout);
    end
    for (int i = 0; i < wq.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (wq[i].data !== e || wq[i].addr !== 32'(i % 32)) begin
        errors++;
        $display("FAIL loop_write[%0d]: got a=%0d d=%h, expected a=%0d d=%h",
                 i, wq[i].addr, wq[i].data, i % 32, e);
      end
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != 66 || done_cyc[1] != 132) begin
      errors++;
      $display("FAIL loop_done: got n=%0d %0d,%0d, expected 66,132", done_cyc.size(), done_cyc[0], done_cyc[1]);
    end
    checks++;
    if (pass_at_done[0] !== 1'b1 || pass_at_done[1] !== 1'b1) begin
      errors++;
      $display("FAIL loop_pass: got %b%b, expected 11", pass_at_done[0], pass_at_done[1]);
    end
    checks++;
    if (busy_low != 133 || wq[32].cyc != 67) begin
      errors++;
      $display("FAIL loop_busy: got low@%0d wr2@%0d, expected 133 and 67", busy_low, wq[32].cyc);
    end
  endtask

  task automatic test_fault;
    fault_en = 1'b1;
    run(0, 2'b00, 1'b0, 1, 200, -10);
    fault_en = 1'b0;
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 66) begin
      errors++;
      $display("FAIL fault_done: got n=%0d cyc=%0d, expected 66", done_cyc.size(), done_cyc[0]);
    end
    checks++;
    if (pass_at_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL fault_pass: got %b, expected 0", pass_at_done[0]);
    end
    checks++;
    if (ea0 !== 5'd5) begin
      errors++;
      $display("FAIL fault_err_addr: got %0d, expected 5", ea0);
    end
`ifdef RAM_RW_ERR_CNT_EN
    checks++;
    if (ec0 !== 16'd2) begin
      errors++;
      $display("FAIL fault_errcnt: got %0d, expected 2", ec0);
    end
`endif
  endtask

  task automatic test_modes;
    logic [31:0] e;
    for (int m = 1; m < 3; m++) begin
      exp_q.delete();
      for (int a = 0; a < 32; a++) exp_q.push_back(exp_pat(8, a, 0, m));
      run(0, 2'(m), 1'b0, 1, 200, -10);
      for (int i = 0; i < wq.size(); i++) begin
        e = exp_q.pop_front();
        checks++;
        if (wq[i].data !== e) begin
          errors++;
          $display("FAIL mode%0d_write[%0d]: got %h, expected %h", m, i, wq[i].data, e);
        end
      end
      checks++;
      if (wq.size() != 32 || pass_at_done.size() != 1 || pass_at_done[0] !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_pass: got n=%0d pass=%b, expected 32 and 1", m, wq.size(), pass_at_done[0]);
      end
    end
  endtask

  task automatic test_wide;
    logic [31:0] e;
    exp_q.delete();
    for (int a = 0; a < 40; a++) exp_q.push_back(exp_pat(16, a, 0, 3));
    run(1, 2'b11, 1'b0, 1, 300, -10);
    checks++;
    if (wq.size() != 40 || rq.size() != 40) begin
      errors++;
      $display("FAIL wide_count: got w=%0d r=%0d, expected 40/40", wq.size(), rq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (wq[i].data !== e || wq[i].addr !== 32'(i)) begin
        errors++;
        $display("FAIL wide_write[%0d]: got a=%0d d=%h, expected a=%0d d=%h", i, wq[i].addr, wq[i].data, i, e);
      end
    end
    checks++;
    if (wq[17].data !== 32'h0002 || wq[16].data !== 32'h0001) begin
      errors++;
      $display("FAIL wide_walk: got %h,%h, expected 0001,0002", wq[16].data, wq[17].data);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 83 || pass_at_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL wide_done: got cyc=%0d pass=%b, expected 83 and 1", done_cyc[0], pass_at_done[0]);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    sel = 0; cur_mode = 2'b00; cur_loop = 1'b0;
    @(negedge clk); cur_start = 1'b1;
    @(negedge clk); cur_start = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b, expected 1", busy0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({en0, wea0, addr0, wd0, busy0, done0, pass0, ea0} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, expected 0", {en0, wea0, addr0, wd0, busy0, done0, pass0, ea0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (70) begin
      @(negedge clk);
      saw_done |= done0 | busy0;
    end
    checks++;
    if (saw_done !== 1'b0 || pass0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got activity=%b pass=%b, expected 0 0", saw_done, pass0);
    end
    run(0, 2'b00, 1'b0, 1, 200, -10);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 66 || pass_at_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rerun: got cyc=%0d pass=%b, expected 66 and 1", done_cyc[0], pass_at_done[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    exp_q.delete();
    for (int a = 0; a < 32; a++) exp_q.push_back(exp_pat(8, a, 0, 0));
    run(0, 2'b00, 1'b0, 1, 200, 10);
    for (int i = 0; i < wq.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (wq[i].data !== e || wq[i].cyc != i + 1) begin
        errors++;
        $display("FAIL b2b_write[%0d]: got d=%h c=%0d, expected d=%h c=%0d", i, wq[i].data, wq[i].cyc, e, i + 1);
      end
    end
    checks++;
    if (wq.size() != 32 || done_cyc.size() != 1 || done_cyc[0] != 66 || pass_at_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got n=%0d done=%0d@%0d pass=%b, expected 32 1@66 1",
               wq.size(), done_cyc.size(), done_cyc[0], pass_at_done[0]);
    end
  endtask

  initial begin
    sel = 0; cur_start = 1'b0; cur_mode = 2'b00; cur_loop = 1'b0; fault_en = 1'b0;
    test_reset();
    test_mode0();
    test_loop();
    test_fault();
    test_modes();
    test_wide();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
